// File: rtl/aes_axis_out_tx_pkg.sv
// Shared constants and types for the AES output-stream transmitter.
//   WORD_S        : stream word width in bits
//   NB            : words per AES block
//   OUT_BLK_WORDS : beats emitted per output block
//   BLK_BITS      : output SRAM word width
//   out_tx_state_e: transmitter FSM states
package aes_axis_out_tx_pkg;

  localparam int unsigned WORD_S        = 32;
  localparam int unsigned NB            = 4;
  localparam int unsigned OUT_BLK_WORDS = NB;
  localparam int unsigned BLK_BITS      = NB * WORD_S;
  localparam int unsigned OUT_IDX_W     = $clog2(OUT_BLK_WORDS);

  typedef enum logic [2:0] {
    OT_IDLE,
    OT_FETCH,
    OT_LOAD,
    OT_SEND,
    OT_DONE
  } out_tx_state_e;

  // Requested block count limited to the SRAM depth.
  function automatic int unsigned clamp_blocks(input int unsigned cnt,
                                               input int unsigned depth);
    return (cnt > depth) ? depth : cnt;
  endfunction

endpackage

// File: rtl/aes_axis_out_tx_if.sv
// AXI-Stream bundle for the AES output transmitter.
//   master modport: drives tvalid/tdata/tstrb/tlast, samples tready
//   slave  modport: the opposite direction
interface aes_axis_out_tx_if #(
  parameter int unsigned TDATA_WIDTH = 32
);
  logic                     tvalid;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic                     tlast;
  logic                     tready;

  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/aes_axis_out_tx_blk_word_unpacker.sv
// Two-entry block buffer that splits 128-bit blocks into 32-bit beats.
//   clk        : clock
//   clear      : synchronous clear of all state
//   din_valid  : din/din_last present (SRAM read data one cycle after r_e)
//   din        : block from the output SRAM
//   din_last   : din is the final block of the packet
//   advance    : current beat handshaken
//   word       : current beat (registered, MSW first)
//   word_valid : current beat valid (registered)
//   word_last  : current beat is the last beat of the packet (registered)
//   word_idx   : index of the current beat within its block
//   nxt_valid  : prefetch slot occupied
module blk_word_unpacker
  import aes_axis_out_tx_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_S,
  parameter int unsigned BLK_W  = BLK_BITS
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 din_valid,
  input  logic [BLK_W-1:0]     din,
  input  logic                 din_last,
  input  logic                 advance,
  output logic [WORD_W-1:0]    word,
  output logic                 word_valid,
  output logic                 word_last,
  output logic [OUT_IDX_W-1:0] word_idx,
  output logic                 nxt_valid
);

  localparam logic [OUT_IDX_W-1:0] LAST_IDX = OUT_IDX_W'(BLK_W / WORD_W - 1);
  localparam logic [OUT_IDX_W-1:0] PEN_IDX  = OUT_IDX_W'(BLK_W / WORD_W - 2);

  logic [BLK_W-1:0]     cur_q, cur_d, nxt_q, nxt_d;
  logic                 cur_last_q, cur_last_d, nxt_last_q, nxt_last_d;
  logic                 cur_valid_q, cur_valid_d, nxt_valid_q, nxt_valid_d;
  logic [OUT_IDX_W-1:0] idx_q, idx_d;
  logic                 last_q, last_d;

  // cur_blk is shifted left on every beat so the outgoing word is always the
  // top slice of a register; tlast is likewise precomputed one beat early.
  always_comb begin
    cur_d       = cur_q;
    cur_last_d  = cur_last_q;
    cur_valid_d = cur_valid_q;
    nxt_d       = nxt_q;
    nxt_last_d  = nxt_last_q;
    nxt_valid_d = nxt_valid_q;
    idx_d       = idx_q;
    last_d      = last_q;

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        idx_d  = '0;
        last_d = 1'b0;
        if (nxt_valid_q) begin
          cur_d       = nxt_q;
          cur_last_d  = nxt_last_q;
          nxt_valid_d = 1'b0;
        end else begin
          cur_valid_d = 1'b0;
        end
      end else begin
        cur_d  = cur_q << WORD_W;
        idx_d  = idx_q + OUT_IDX_W'(1);
        last_d = cur_last_q && (idx_q == PEN_IDX);
      end
    end

    // Arriving data fills the current slot if it has drained, else the
    // prefetch slot.
    if (din_valid) begin
      if (!cur_valid_d) begin
        cur_d       = din;
        cur_last_d  = din_last;
        cur_valid_d = 1'b1;
        idx_d       = '0;
        last_d      = 1'b0;
      end else begin
        nxt_d       = din;
        nxt_last_d  = din_last;
        nxt_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cur_q       <= '0;
      cur_last_q  <= 1'b0;
      cur_valid_q <= 1'b0;
      nxt_q       <= '0;
      nxt_last_q  <= 1'b0;
      nxt_valid_q <= 1'b0;
      idx_q       <= '0;
      last_q      <= 1'b0;
    end else begin
      cur_q       <= cur_d;
      cur_last_q  <= cur_last_d;
      cur_valid_q <= cur_valid_d;
      nxt_q       <= nxt_d;
      nxt_last_q  <= nxt_last_d;
      nxt_valid_q <= nxt_valid_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
    end
  end

  assign word       = cur_q[BLK_W-1 -: WORD_W];
  assign word_valid = cur_valid_q;
  assign word_last  = last_q;
  assign word_idx   = idx_q;
  assign nxt_valid  = nxt_valid_q;

endmodule

// File: rtl/aes_axis_out_tx.sv
// AES output-stream transmitter: reads result blocks from the output SRAM and
// sends each as four AXI-Stream beats, most significant word first.
//   clk, reset     : single clock, synchronous active-high reset
//   start, blk_cnt : begin a packet of blk_cnt blocks (clamped to DEPTH)
//   out_sram_*     : output SRAM read port (data one cycle after r_e)
//   m00_axis       : AXI-Stream master
//   busy, done     : packet in progress / one-cycle completion strobe
module aes_axis_out_tx
  import aes_axis_out_tx_pkg::*;
#(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned BLK_WIDTH            = 128,
  parameter int unsigned ADDR_WIDTH           = 9,
  parameter int unsigned DEPTH                = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   blk_cnt,
  output logic                  out_sram_r_e,
  output logic [ADDR_WIDTH-1:0] out_sram_addr,
  input  logic [BLK_WIDTH-1:0]  out_sram_data,
  aes_axis_out_tx_if.master     m00_axis,
  output logic                  busy,
  output logic                  done
);

  localparam logic [OUT_IDX_W-1:0] LAST_WORD =
    OUT_IDX_W'(BLK_WIDTH / C_M_AXIS_TDATA_WIDTH - 1);

  out_tx_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   rd_left_q;
  logic [ADDR_WIDTH:0]   blocks_left_q;
  logic                  pf_pend_q, pf_last_q;
  logic [ADDR_WIDTH:0]   cnt_clamped;
  logic                  rd_en;

  logic [C_M_AXIS_TDATA_WIDTH-1:0] up_word;
  logic                            up_valid, up_last, up_nxt_valid;
  logic [OUT_IDX_W-1:0]            up_idx;
  logic                            hs, blk_hs, last_hs;

  assign cnt_clamped = (ADDR_WIDTH+1)'(clamp_blocks(32'(blk_cnt), DEPTH));
  assign hs          = up_valid && m00_axis.tready;
  assign blk_hs      = hs && (up_idx == LAST_WORD);
  assign last_hs     = blk_hs && (blocks_left_q == (ADDR_WIDTH+1)'(1));

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      OT_IDLE: begin
        busy = 1'b0;
        if (start) state_d = (cnt_clamped == '0) ? OT_DONE : OT_FETCH;
      end
      OT_FETCH: begin
        rd_en   = 1'b1;
        state_d = OT_LOAD;
      end
      OT_LOAD: state_d = OT_SEND;
      OT_SEND: begin
        // Keep at most one block buffered ahead of the one being sent.
        rd_en = (rd_left_q != '0) && !up_nxt_valid && !pf_pend_q;
        if (last_hs) state_d = OT_DONE;
      end
      OT_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = OT_IDLE;
      end
      default: state_d = OT_IDLE;
    endcase
  end

  // Every read carries a "last block" tag that travels with the data into the
  // unpacker, so tlast needs no look-back at blocks_left once buffered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= OT_IDLE;
      rd_ptr_q      <= '0;
      rd_left_q     <= '0;
      blocks_left_q <= '0;
      pf_pend_q     <= 1'b0;
      pf_last_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pf_pend_q <= rd_en;
      if (state_q == OT_IDLE && start) begin
        rd_ptr_q      <= '0;
        rd_left_q     <= cnt_clamped;
        blocks_left_q <= cnt_clamped;
      end
      if (rd_en) begin
        rd_left_q <= rd_left_q - (ADDR_WIDTH+1)'(1);
        pf_last_q <= (rd_left_q == (ADDR_WIDTH+1)'(1));
        if (rd_ptr_q != ADDR_WIDTH'(DEPTH - 1)) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      end
      if (blk_hs) blocks_left_q <= blocks_left_q - (ADDR_WIDTH+1)'(1);
    end
  end

  blk_word_unpacker #(
    .WORD_W (C_M_AXIS_TDATA_WIDTH),
    .BLK_W  (BLK_WIDTH)
  ) u_unpacker (
    .clk        (clk),
    .clear      (reset),
    .din_valid  (pf_pend_q),
    .din        (out_sram_data),
    .din_last   (pf_last_q),
    .advance    (hs),
    .word       (up_word),
    .word_valid (up_valid),
    .word_last  (up_last),
    .word_idx   (up_idx),
    .nxt_valid  (up_nxt_valid)
  );

  assign out_sram_r_e    = rd_en;
  assign out_sram_addr   = rd_ptr_q;
  assign m00_axis.tvalid = up_valid;
  assign m00_axis.tdata  = up_word;
  assign m00_axis.tlast  = up_last;
  assign m00_axis.tstrb  = '1;

endmodule

// File: tb/tb_aes_axis_out_tx.sv
module tb_aes_axis_out_tx;

  localparam int unsigned AW    = 9;
  localparam int unsigned DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW:0]   blk_cnt;
  logic          r_e;
  logic [AW-1:0] addr;
  logic [127:0]  sram_q;
  logic          busy, done;

  aes_axis_out_tx_if #(.TDATA_WIDTH(32)) m00_axis();

  aes_axis_out_tx #(
    .C_M_AXIS_TDATA_WIDTH (32),
    .BLK_WIDTH            (128),
    .ADDR_WIDTH           (AW),
    .DEPTH                (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .blk_cnt       (blk_cnt),
    .out_sram_r_e  (r_e),
    .out_sram_addr (addr),
    .out_sram_data (sram_q),
    .m00_axis      (m00_axis),
    .busy          (busy),
    .done          (done)
  );

  initial forever #5 clk = ~clk;

  // Output block SRAM: registered read, data valid the cycle after r_e.
  logic [127:0] mem [DEPTH];
  always @(posedge clk) if (r_e) sram_q <= mem[addr];

  // Scoreboard state
  logic [32:0]  exp_q [$];
  int unsigned  rd_q  [$];
  int unsigned  checks = 0, failures = 0;
  int unsigned  pkt_beats = 0, pkt_reads = 0, done_cnt = 0;
  int unsigned  tr_mode = 0, low_run = 0;
  bit           prev_stall = 0;
  logic [31:0]  prev_data;
  logic         prev_last;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: block b of the packet gives beats MSW first; only the final
  // beat of the final block carries tlast. Reads go to addresses 0..n-1.
  task automatic push_expected(input int unsigned nn);
    logic [127:0] blk;
    for (int unsigned b = 0; b < nn; b++) begin
      blk = mem[b];
      rd_q.push_back(b);
      for (int unsigned w = 0; w < 4; w++)
        exp_q.push_back({(b == nn - 1) && (w == 3), blk[127 - 32*w -: 32]});
    end
  endtask

  // Monitor: samples between active edges.
  initial forever begin
    logic [32:0] e;
    @(negedge clk);
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid_hold", 32'(m00_axis.tvalid), 1);
        chk("stall_tdata_hold", m00_axis.tdata, prev_data);
        chk("stall_tlast_hold", 32'(m00_axis.tlast), 32'(prev_last));
      end
      prev_stall = m00_axis.tvalid && !m00_axis.tready;
      prev_data  = m00_axis.tdata;
      prev_last  = m00_axis.tlast;
      if (m00_axis.tvalid && m00_axis.tready) begin
        pkt_beats++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none t=%0t", m00_axis.tdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("beat_tdata", m00_axis.tdata, e[31:0]);
          chk("beat_tlast", 32'(m00_axis.tlast), 32'(e[32]));
        end
      end
      if (r_e) begin
        pkt_reads++;
        checks++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_read actual=%0d required=none t=%0t", addr, $time);
        end else begin
          chk("sram_addr", 32'(addr), rd_q.pop_front());
        end
        chk("prefetch_depth", 32'(pkt_reads <= pkt_beats / 4 + 2), 1);
      end
      if (done) done_cnt++;
    end
  end

  // tready: mode 0 always high, mode 1 random with long low bursts.
  initial begin
    m00_axis.tready = 1'b1;
    forever begin
      tick();
      if (tr_mode == 0) m00_axis.tready = 1'b1;
      else if (low_run > 0) begin
        m00_axis.tready = 1'b0;
        low_run--;
      end else if ($urandom_range(0, 11) == 0) begin
        m00_axis.tready = 1'b0;
        low_run = 19;
      end else m00_axis.tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic run_pkt(input int unsigned n, input bit exact, input bit poke);
    int unsigned nn, k, d0, lim;
    nn = (n > DEPTH) ? DEPTH : n;
    push_expected(nn);
    pkt_beats = 0;
    pkt_reads = 0;
    d0  = done_cnt;
    lim = exact ? 4*nn + 20 : 4000;
    tick();
    blk_cnt = n[AW:0];
    start   = 1'b1;
    tick();
    start = 1'b0;
    k     = 1;
    chk("busy_after_start", 32'(busy), 32'(nn > 0));
    chk("re_after_start", 32'(r_e), 32'(nn > 0));
    if (nn > 0) begin
      while (!m00_axis.tvalid && k < 10) begin tick(); k++; end
      chk("first_tvalid_latency", k, 3);
      if (poke) begin
        blk_cnt = 2;
        start   = 1'b1;
        tick(); k++;
        start = 1'b0;
      end
    end
    while (!done && k < lim) begin tick(); k++; end
    if (exact) chk("done_latency", k, (nn == 0) ? 1 : 3 + 4*nn);
    else       chk("done_seen", 32'(done), 1);
    repeat (3) tick();
    chk("done_pulses", done_cnt - d0, 1);
    chk("beats_outstanding", exp_q.size(), 0);
    chk("reads_outstanding", rd_q.size(), 0);
    chk("idle_tvalid", 32'(m00_axis.tvalid), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned k, d0;
    reset   = 1'b1;
    start   = 1'b0;
    blk_cnt = '0;
    for (int unsigned a = 0; a < DEPTH; a++) mem[a] = rand128();
    repeat (3) tick();
    chk("rst_tvalid", 32'(m00_axis.tvalid), 0);
    chk("rst_tlast", 32'(m00_axis.tlast), 0);
    chk("rst_tdata", m00_axis.tdata, 0);
    chk("rst_tstrb", 32'(m00_axis.tstrb), 32'hF);
    chk("rst_re", 32'(r_e), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;
    tick();

    // Single known block, plus a start pulse while busy.
    mem[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    run_pkt(1, 1'b1, 1'b1);

    // Three random blocks, back-to-back with tready high.
    for (int unsigned a = 0; a < 3; a++) mem[a] = rand128();
    run_pkt(3, 1'b1, 1'b0);

    // Same blocks with tready stalls.
    low_run = 10;
    tr_mode = 1;
    run_pkt(3, 1'b0, 1'b0);
    tr_mode = 0;
    repeat (2) tick();

    // Empty packet.
    run_pkt(0, 1'b1, 1'b0);

    // Full depth with address-indexed data, then an over-depth request.
    for (int unsigned a = 0; a < DEPTH; a++)
      mem[a] = {a, ~a, a * 32'h9E3779B1, 32'hA5A50000 ^ a};
    run_pkt(512, 1'b1, 1'b0);
    run_pkt(700, 1'b1, 1'b0);

    // Reset after beat 5 of a two-block packet.
    mem[0] = rand128();
    mem[1] = rand128();
    push_expected(2);
    pkt_beats = 0;
    pkt_reads = 0;
    tick();
    blk_cnt = 2;
    start   = 1'b1;
    tick();
    start = 1'b0;
    k     = 0;
    while (pkt_beats < 5 && k < 50) begin tick(); k++; end
    chk("rst_mid_beats", pkt_beats, 5);
    reset = 1'b1;
    exp_q.delete();
    rd_q.delete();
    d0 = done_cnt;
    tick();
    chk("rst_mid_tvalid", 32'(m00_axis.tvalid), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    reset = 1'b0;
    repeat (6) tick();
    chk("rst_mid_no_done", done_cnt - d0, 0);
    chk("rst_mid_idle_tvalid", 32'(m00_axis.tvalid), 0);

    mem[0] = rand128();
    run_pkt(1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
